// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Purpose : Shared ALU control-code definitions used by the ALU datapath and
//           by every block that sequences it.
// Contents: ALU_CTL_W      - width of the ALU control field
//           ALU_AND..NOR   - supported control codes; any other code
//                            produces result 0 / zero 1
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_CTL_W = 4;

  localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'd12;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_arbiter_if
// Purpose   : Request/response bundle between NREQ requesters and the shared
//             ALU arbiter.
// Signals   : req_valid/req_ready  per-requester request handshake
//             req_a/req_b/req_ctl  flattened operands, requester i at slice i
//             rsp_valid/rsp_ready  per-requester response handshake
//             rsp_data/rsp_zero    shared result bus
// Modports  : slave  - arbiter side
//             master - requester side
// Revision  : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 2
);
  import alu_pkg::*;

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*DWIDTH-1:0]    req_a;
  logic [NREQ*DWIDTH-1:0]    req_b;
  logic [NREQ*ALU_CTL_W-1:0] req_ctl;
  logic [NREQ-1:0]           rsp_valid;
  logic [NREQ-1:0]           rsp_ready;
  logic [DWIDTH-1:0]         rsp_data;
  logic                      rsp_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_ctl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport master (
    output req_valid, req_a, req_b, req_ctl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

endinterface : alu_arbiter_if
`default_nettype wire

// File: rtl/ALU.sv
`default_nettype none
// ============================================================================
// Module  : ALU
// Purpose : Combinational integer datapath shared by the requesters.
// Ports   : i_a, i_b   operands (DWIDTH)
//           i_ctl      control code (see alu_pkg)
//           o_result   operation result
//           o_zero     high when o_result is all zeros
// Revision: 1.0 - initial release
// ============================================================================
module ALU
  import alu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  wire logic [DWIDTH-1:0]    i_a,
  input  wire logic [DWIDTH-1:0]    i_b,
  input  wire logic [ALU_CTL_W-1:0] i_ctl,
  output logic      [DWIDTH-1:0]    o_result,
  output logic                      o_zero
);

  always_comb begin
    o_result = '0;
    case (i_ctl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      // Unsigned compare, zero-extended to a 0/1 word.
      ALU_SLT: o_result = {{(DWIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_NOR: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule : ALU
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin selector. Searches i_valid starting at
//           i_last+1 (mod NREQ) and grants the first asserted request.
// Ports   : i_valid     request vector
//           i_last      id granted most recently
//           o_grant     one-hot grant (zero when nothing is valid)
//           o_grant_id  binary id of the grant (0 when nothing is valid)
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0] i_valid,
  input  wire logic [IDW-1:0]  i_last,
  output logic      [NREQ-1:0] o_grant,
  output logic      [IDW-1:0]  o_grant_id
);

  // Walk from the farthest candidate back to the nearest so the one closest
  // after i_last is written last and therefore wins.
  always_comb begin
    int idx;
    idx        = 0;
    o_grant    = '0;
    o_grant_id = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(i_last) + k) % NREQ;
      if (i_valid[idx]) begin
        o_grant      = '0;
        o_grant[idx] = 1'b1;
        o_grant_id   = IDW'(idx);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Purpose : Shares one ALU between NREQ requesters. Round-robin arbitration
//           feeds a two-stage pipeline: operand register (S1) -> ALU ->
//           result register (S2). One operation per cycle without response
//           backpressure; at most two operations in flight.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    alu_arbiter_if.slave request/response bundle
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int DWIDTH = 32,
  parameter  int NREQ   = 2,
  localparam int IDW    = $clog2(NREQ)
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  alu_arbiter_if.slave   bus
);

  // S1 operand stage
  logic                 r_s1_valid;
  logic [IDW-1:0]       r_s1_id;
  logic [DWIDTH-1:0]    r_s1_a;
  logic [DWIDTH-1:0]    r_s1_b;
  logic [ALU_CTL_W-1:0] r_s1_ctl;

  // S2 result stage
  logic                 r_s2_valid;
  logic [IDW-1:0]       r_s2_id;
  logic [DWIDTH-1:0]    r_s2_data;
  logic                 r_s2_zero;

  logic [IDW-1:0]       r_last;

  logic                 w_s2_stall;
  logic                 w_s1_adv;
  logic                 w_can_accept;
  logic [NREQ-1:0]      w_pick_grant;
  logic [IDW-1:0]       w_pick_id;
  logic [NREQ-1:0]      w_grant;
  logic                 w_xfer;
  logic [DWIDTH-1:0]    w_alu_result;
  logic                 w_alu_zero;

  assign w_s2_stall   = r_s2_valid && !bus.rsp_ready[r_s2_id];
  assign w_s1_adv     = r_s1_valid && !w_s2_stall;
  assign w_can_accept = !r_s1_valid || w_s1_adv;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_valid    (bus.req_valid),
    .i_last     (r_last),
    .o_grant    (w_pick_grant),
    .o_grant_id (w_pick_id)
  );

  // rst_n gates the grant so no requester sees ready while reset is held.
  assign w_grant       = (w_can_accept && rst_n) ? w_pick_grant : '0;
  assign w_xfer        = |w_grant;
  assign bus.req_ready = w_grant;

  // S1 loads whenever it is empty or handing its operation to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ctl   <= '0;
      r_last     <= IDW'(NREQ - 1);
    end else begin
      if (w_can_accept) begin
        r_s1_valid <= w_xfer;
        if (w_xfer) begin
          r_s1_id  <= w_pick_id;
          r_s1_a   <= bus.req_a[int'(w_pick_id)*DWIDTH +: DWIDTH];
          r_s1_b   <= bus.req_b[int'(w_pick_id)*DWIDTH +: DWIDTH];
          r_s1_ctl <= bus.req_ctl[int'(w_pick_id)*ALU_CTL_W +: ALU_CTL_W];
        end
      end
      if (w_xfer) begin
        r_last <= w_pick_id;
      end
    end
  end

  ALU #(
    .DWIDTH (DWIDTH)
  ) u_alu (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_ctl    (r_s1_ctl),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  // S2 holds while stalled; otherwise it drains and reloads from S1 in the
  // same edge (no bubble when both happen together).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_data  <= '0;
      r_s2_zero  <= 1'b0;
    end else if (!w_s2_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id   <= r_s1_id;
        r_s2_data <= w_alu_result;
        r_s2_zero <= w_alu_zero;
      end
    end
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (r_s2_valid) begin
      bus.rsp_valid[r_s2_id] = 1'b1;
    end
  end

  assign bus.rsp_data = r_s2_data;
  assign bus.rsp_zero = r_s2_zero;

endmodule : alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one instance of the team's `ALU` datapath between `NREQ` requesters, such as the integer pipe and the branch/address unit, through a valid/ready request port and a valid/ready response port. Arbitration is round-robin. The block has a two-stage pipeline: an operand register, then the combinational ALU, then a result register. It sustains one operation per cycle when there is no response backpressure. It sits between the requesters and the ALU, and owns all sequencing of it.

## Interface
- `DWIDTH`, 32, operand/result width passed to `ALU`
- `NREQ`, 2, number of requesters (legal 2..4)
- `IDW`, derived = clog2(`NREQ`), requester-id width (localparam)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero
- `req_a`  in  NREQ*DWIDTH  flattened operand A; requester i at [i*DWIDTH +: DWIDTH]
- `req_b`  in  NREQ*DWIDTH  flattened operand B
- `req_ctl`  in  NREQ*4  flattened ALU control code
- `rsp_valid`  out  NREQ  one-hot: result pending for requester i
- `rsp_ready`  in  NREQ  per-requester response accept
- `rsp_data`  out  DWIDTH  result, shared by all requesters
- `rsp_zero`  out  1  result == 0

## Operation
ALU control codes:
- 0 AND
- 1 OR
- 2 ADD
- 6 SUB
- 7 SLT (unsigned, result 0/1)
- 12 NOR
- any other code gives result 0, zero=1

Request handshake:
- A request transfers when `req_valid[i] && req_ready[i]` at a rising edge.
- A requester must hold `req_a`/`req_b`/`req_ctl` stable while valid and not ready.

Pipeline state:
- S1 (operand stage): `s1_valid`, `s1_id`, A, B, ctl.
- S2 (result stage): `s2_valid`, `s2_id`, data, zero.

Stall and advance logic:
- `s2_stall = s2_valid && !rsp_ready[s2_id]`.
- `s1_adv = s1_valid && !s2_stall`.
- `can_accept = !s1_valid || s1_adv`.

Arbitration:
- Pointer `last` (IDW bits).
- Search starts at `last+1` mod NREQ.
- The first asserted `req_valid` is granted, only when `can_accept`.
- `last` updates to the granted id on each transfer only.
- `req_ready` is combinational from `req_valid`, S1/S2 state and `rsp_ready[s2_id]`. There are no other combinational paths.

Response handshake:
- `rsp_valid = s2_valid ? onehot(s2_id) : 0`.
- S2 clears or reloads when `rsp_ready[s2_id]` is high.

## Timing
- Reset, and `rst_n` low at any time, including mid-operation:
  - `s1_valid`, `s2_valid` = 0; all in-flight operations are dropped.
  - `last` = NREQ-1, so requester 0 wins first.
  - `req_ready` = 0; `req_ready` is also forced 0 while `rst_n` is low.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_zero` = 0.
- Latency: a request accepted at edge k has its `rsp_valid` high after edge k+1, when S2 is free or draining at k+1.
- Throughput: back-to-back grants every cycle while `rsp_ready` of the S2 owner is high.
- Simultaneous events:
  - S2 draining and S1 advancing in the same edge: S2 reloads with no bubble.
  - S1 advancing and a new grant in the same edge: S1 reloads.
- Full condition: S1 and S2 both valid and S2 stalled gives `req_ready` = 0 for all requesters.
- At most 2 operations are in flight.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Wrap-around: `last` wraps from NREQ-1 to 0.
- A response is never dropped or reordered. Results return in acceptance order.

## Structure
- Shared package `alu_pkg`:
  - localparams for the ctl codes (`ALU_AND`=0, `ALU_OR`=1, `ALU_ADD`=2, `ALU_SUB`=6, `ALU_SLT`=7, `ALU_NOR`=12)
  - `ALU_CTL_W`=4
- Sub-module: the existing `ALU` instantiated once between S1 and S2, with `DWIDTH` passed through.
- The round-robin pick is a natural sub-module, `rr_pick` (NREQ-wide: valid + last in, grant one-hot out), reusable elsewhere.

## Test plan
1. Reset, then req0 only: A=5, B=3, ctl=2 → `rsp_valid`=01 two edges after assert, `rsp_data`=8, `rsp_zero`=0. ctl=6 with A=B=7 → data 0, zero=1.
2. Both requesters valid every cycle, `rsp_ready`=11 → grants alternate 0,1,0,1; responses return in grant order at 1 op/cycle. Check SLT (A=1, B=2 → 1) and NOR (A=B=0 → 0xFFFFFFFF).
3. `rsp_ready`=00 with streams running → exactly 2 ops accepted, then `req_ready`=00. Release `rsp_ready` → drain in order, no loss, no duplicate.
4. req1 granted last, then req0 and req1 both valid → req0 granted first. With NREQ=3, pointer wraps 2→0.
5. Unknown ctl=9, A=0xFFFF, B=1 → data 0, zero=1.
6. Assert `rst_n` low while S1 and S2 are valid → `rsp_valid`, `req_ready` go 0 immediately; after release, req0 has priority and no stale response appears.
